bl_wl_config_loader: RTL and testbench
======================================

// Module: bl_wl_config_loader
// PURPOSE
//  Sequences frame-based BL/WL configuration memory for one tile column/row bank.
//  Accepts a valid/ready word stream and assembles one BL frame per WL row.
//  For each assembled frame it drives the frame onto cfg_bl, then pulses the row's WL line with setup/hold margins.
//  Sits between the bitstream DMA/scan front-end and the tile bl_in/wl_in chain.
// PARAMETERS
//  BL_WIDTH   315  bits per frame; drives tile bl_in
//  WL_WIDTH   4    number of rows (WL lines); drives tile wl_in
//  DATA_W     32   input stream word width
//  SETUP_CYC  2    cycles BL stable before WL rises (>=1)
//  PULSE_CYC  2    cycles WL high (>=1)
//  HOLD_CYC   1    cycles BL stable after WL falls (>=1)
//  Derived localparam WORDS = ceil(BL_WIDTH/DATA_W)
// PORTS
//  clk        in   1         clock; all logic on posedge
//  reset      in   1         asynchronous active-low reset; 0 = reset asserted
//  start      in   1         one-cycle request to begin programming; sampled in IDLE/DONE/ERR only
//  busy       out  1         high from the cycle after start until DONE or ERR
//  done       out  1         high in DONE; cleared by next accepted start
//  err        out  1         high in ERR (framing error); cleared by next accepted start
//  cfg_valid  in   1         stream word valid
//  cfg_ready  out  1         loader can accept; high only in LOAD
//  cfg_data   in   DATA_W    stream word; word k fills cfg_bl[k*DATA_W +: DATA_W]
//  cfg_last   in   1         marks final word of the whole bitstream
//  cfg_bl     out  BL_WIDTH  frame data to tile bl_in
//  cfg_wl     out  WL_WIDTH  row strobe to tile wl_in; one-hot or zero
// BEHAVIOUR
//  Reset values: cfg_bl=0, cfg_wl=0, cfg_ready=0, busy=0, done=0, err=0; state IDLE; row=0, word=0.
//  Reset mid-operation clears cfg_wl asynchronously; WL must never remain high across reset.
//  Transfer: cfg_valid & cfg_ready in the same cycle; one word per cycle max; data is not buffered outside handshake.
//  IDLE:  start -> LOAD; row=0, word=0, done=0, err=0, busy=1.
//  LOAD:  cfg_ready=1; each transfer writes the word slot, word++.
//         Bits of the last word beyond BL_WIDTH are ignored.
//         When word==WORDS-1 transfers -> SETUP; word=0.
//         Framing: cfg_last on a transfer other than the final word of row WL_WIDTH-1 -> ERR.
//         Missing cfg_last on that final word -> ERR.
//  SETUP: cfg_wl=0, cfg_bl held, SETUP_CYC cycles -> PULSE.
//  PULSE: cfg_wl = 1<<row for exactly PULSE_CYC cycles -> HOLD.
//  HOLD:  cfg_wl=0 for HOLD_CYC cycles.
//         If row==WL_WIDTH-1 -> DONE; else row++ -> LOAD.
//  DONE:  done=1, busy=0, cfg_bl keeps last frame; start -> LOAD as from IDLE.
//  ERR:   err=1, busy=0, cfg_wl=0, cfg_ready=0; start -> LOAD as from IDLE.
//  start outside IDLE/DONE/ERR is ignored. cfg_valid outside LOAD is ignored (ready=0).
//  Timing: cfg_wl never changes in the same cycle as cfg_bl. cfg_wl is a registered output, not decoded combinationally.
//  Min cycles per row = WORDS + SETUP_CYC + PULSE_CYC + HOLD_CYC.
//  Counters: word is ceil(log2(WORDS+1)) wide; row is ceil(log2(WL_WIDTH+1)) wide; timer covers the max of the three cycle params.
// STRUCTURE
//  Package bl_wl_cfg_pkg: state enum (IDLE, LOAD, SETUP, PULSE, HOLD, DONE, ERR) and the clog2/ceil-div helper functions.
//  One sub-module: bl_wl_phase_timer (load/count-down/expire), reused for SETUP, PULSE and HOLD.
// TESTING (BL_WIDTH=40, WL_WIDTH=4, DATA_W=16, WORDS=3, SETUP=2, PULSE=2, HOLD=1)
//  Full program, 12 words with last on word 12, valid held high:
//    -> wl = 0001, 0010, 0100, 1000, each high exactly 2 cycles;
//    -> cfg_bl = {w2[7:0], w1, w0} during row 0; done after 32 cycles; busy low after.
//  cfg_last on word 3 (end of row 0) -> ERR; err=1, wl stays 0, no pulse issued for row 0.
//  No cfg_last on word 12 -> ERR after word 12; row 3 WL never pulses.
//  Random cfg_valid gaps (50%) -> identical wl/bl sequence as the full-program case; cfg_ready is low outside LOAD.
//  reset low while wl=0100 (row 2 PULSE) -> wl=0 same cycle, all outputs at reset values;
//    -> a new start reprograms from row 0.
//  start pulsed during LOAD and during PULSE -> ignored, sequence unchanged;
//    -> start in DONE clears done and restarts at row 0.

Source files
------------

// File: rtl/bl_wl_cfg_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the BL/WL configuration loader.
// Pure definitions only: no logic, so no latency or backpressure of its own.
package bl_wl_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE,
        ST_ERR
    } state_t;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/bl_wl_config_loader_if.sv
// Valid/ready word stream from the bitstream front-end into the loader.
// A word moves only on a cycle where valid and ready are both high; last tags the final word.
interface bl_wl_config_loader_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bl_wl_phase_timer.sv
// Load/count-down phase timer; expire is high while the count sits at zero.
// Loading N gives N+1 cycles until expire; load takes priority over counting.
module bl_wl_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/bl_wl_config_loader.sv
// Assembles one BL frame per WL row from a word stream, then strobes that row with setup/pulse/hold margins.
// WORDS+SETUP+PULSE+HOLD cycles per row minimum; stream is stalled (ready low) outside the LOAD phase.
module bl_wl_config_loader
    import bl_wl_cfg_pkg::*;
#(
    parameter int BL_WIDTH  = 315,
    parameter int WL_WIDTH  = 4,
    parameter int DATA_W    = 32,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    bl_wl_config_loader_if.slave cfg,
    output logic [BL_WIDTH-1:0] cfg_bl,
    output logic [WL_WIDTH-1:0] cfg_wl
);

    localparam int WORDS   = ceil_div(BL_WIDTH, DATA_W);
    localparam int WORD_W  = clog2(WORDS + 1);
    localparam int ROW_W   = clog2(WL_WIDTH + 1);
    localparam int TMR_MAX = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int TMR_W   = clog2(TMR_MAX + 1);

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [ROW_W-1:0]  row;
    logic              ready_q;
    logic              xfer;
    logic              final_word;
    logic              last_row;
    logic              tmr_load;
    logic              tmr_expire;
    logic [TMR_W-1:0]  tmr_val;

    assign cfg.ready  = ready_q;
    assign xfer       = cfg.valid && ready_q;
    assign final_word = (word == WORD_W'(WORDS - 1));
    assign last_row   = (row == ROW_W'(WL_WIDTH - 1));

    // Outside the timed phases the timer is kept primed with the next phase's length,
    // so each phase starts with a full count on the cycle it is entered.
    always_comb begin
        tmr_val  = TMR_W'(SETUP_CYC - 1);
        tmr_load = 1'b1;
        case (state)
            ST_SETUP: begin
                tmr_val  = TMR_W'(PULSE_CYC - 1);
                tmr_load = tmr_expire;
            end
            ST_PULSE: begin
                tmr_val  = TMR_W'(HOLD_CYC - 1);
                tmr_load = tmr_expire;
            end
            ST_HOLD: begin
                tmr_load = tmr_expire;
            end
            default: ;
        endcase
    end

    bl_wl_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            word    <= '0;
            row     <= '0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cfg_wl  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state   <= ST_LOAD;
                        word    <= '0;
                        row     <= '0;
                        ready_q <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        // last must appear exactly on the final word of the final row
                        if (cfg.last != (final_word && last_row)) begin
                            state   <= ST_ERR;
                            ready_q <= 1'b0;
                            busy    <= 1'b0;
                            err     <= 1'b1;
                        end else if (final_word) begin
                            state   <= ST_SETUP;
                            word    <= '0;
                            ready_q <= 1'b0;
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_expire) begin
                        state  <= ST_PULSE;
                        cfg_wl <= WL_WIDTH'(1) << row;
                    end
                end
                ST_PULSE: begin
                    if (tmr_expire) begin
                        state  <= ST_HOLD;
                        cfg_wl <= '0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_expire) begin
                        if (last_row) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_LOAD;
                            row     <= row + ROW_W'(1);
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                    cfg_wl  <= '0;
                end
            endcase
        end
    end

    // Word k lands in bits [k*DATA_W +: DATA_W]; bits of the last word past BL_WIDTH are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_bl <= '0;
        end else if (xfer) begin
            for (int i = 0; i < BL_WIDTH; i++) begin
                if (word == WORD_W'(i / DATA_W)) cfg_bl[i] <= cfg.data[i % DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_bl_wl_config_loader.sv
// Directed bench for bl_wl_config_loader: 40-bit frames, 4 rows, 16-bit words, setup/pulse/hold = 2/2/1.
module tb_bl_wl_config_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [39:0] cfg_bl;
    logic [3:0]  cfg_wl;

    int errors = 0;
    int checks = 0;

    bl_wl_config_loader_if #(.DATA_W(16)) cfg ();

    bl_wl_config_loader #(
        .BL_WIDTH  (40),
        .WL_WIDTH  (4),
        .DATA_W    (16),
        .SETUP_CYC (2),
        .PULSE_CYC (2),
        .HOLD_CYC  (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .cfg    (cfg),
        .cfg_bl (cfg_bl),
        .cfg_wl (cfg_wl)
    );

    always #5 clk = ~clk;

    // Three words per row; the top byte of every third word falls outside the 40-bit frame.
    logic [15:0] words [12] = '{16'h1111, 16'h2222, 16'h33C3,
                                16'h4444, 16'h5555, 16'h66A6,
                                16'h7777, 16'h8888, 16'h99B9,
                                16'hAAAA, 16'hBBBB, 16'hCCDC};
    logic [39:0] exp_bl [4] = '{40'hC3_2222_1111, 40'hA6_5555_4444,
                                40'hB9_8888_7777, 40'hDC_BBBB_AAAA};

    int          n_sent, n_pulses, cyc, done_cyc, err_cyc;
    int          wl_cnt [4];
    logic [3:0]  order [8];
    logic [39:0] pulse_bl [8];
    int          viol_ready, viol_same, viol_hot;
    bit          timed_out, xfer_pending;
    logic        busy1, done1;
    logic [3:0]  prev_wl;
    logic [39:0] prev_bl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a program, then step cycle by cycle feeding words and recording WL activity.
    task automatic run(input bit gaps, input int last_at, input bit inj,
                       input logic [3:0] stop_wl, input int budget);
        n_sent = 0; n_pulses = 0; cyc = 0; done_cyc = -1; err_cyc = -1;
        for (int r = 0; r < 4; r++) wl_cnt[r] = 0;
        viol_ready = 0; viol_same = 0; viol_hot = 0; timed_out = 0; xfer_pending = 0;
        start = 1'b1;
        cfg.valid = 1'b0;
        cfg.last = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        prev_wl = cfg_wl;
        prev_bl = cfg_bl;
        forever begin
            start = inj && (cyc == 2 || (cfg_wl == 4'b0010 && wl_cnt[1] == 1));
            cfg.valid = (n_sent < 12) && (!gaps || $urandom_range(0, 1) == 1);
            cfg.data = words[(n_sent < 12) ? n_sent : 0];
            cfg.last = (n_sent == last_at);
            xfer_pending = cfg.valid && cfg.ready;
            @(posedge clk); #1;
            cyc++;
            if (xfer_pending) n_sent++;
            if (cfg_wl != 4'b0 && prev_wl == 4'b0 && n_pulses < 8) begin
                order[n_pulses] = cfg_wl;
                pulse_bl[n_pulses] = cfg_bl;
                n_pulses++;
            end
            for (int r = 0; r < 4; r++) if (cfg_wl[r]) wl_cnt[r]++;
            if (!$onehot0(cfg_wl)) viol_hot++;
            if (cfg_wl != prev_wl && cfg_bl != prev_bl) viol_same++;
            if (cfg.ready && (cfg_wl != 4'b0 || done || err)) viol_ready++;
            prev_wl = cfg_wl;
            prev_bl = cfg_bl;
            if (cyc == 1) begin
                busy1 = busy;
                done1 = done;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (err) begin
                err_cyc = cyc;
                break;
            end
            if (stop_wl != 4'b0 && cfg_wl == stop_wl) break;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
        cfg.valid = 1'b0;
        cfg.last = 1'b0;
    endtask

    task automatic check_full(input string tag);
        chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_n_pulses"}, 64'(n_pulses), 64'd4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("%s_wl_order%0d", tag, r), 64'(order[r]), 64'(4'b0001 << r));
            chk($sformatf("%s_wl_len%0d", tag, r), 64'(wl_cnt[r]), 64'd2);
            chk($sformatf("%s_bl%0d", tag, r), 64'(pulse_bl[r]), 64'(exp_bl[r]));
        end
        chk({tag, "_ready_outside_load"}, 64'(viol_ready), 64'd0);
        chk({tag, "_wl_bl_same_cycle"}, 64'(viol_same), 64'd0);
        chk({tag, "_wl_onehot"}, 64'(viol_hot), 64'd0);
        chk({tag, "_busy_after_start"}, 64'(busy1), 64'd1);
        chk({tag, "_done_after_start"}, 64'(done1), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bl"}, 64'(cfg_bl), 64'd0);
        chk({tag, "_wl"}, 64'(cfg_wl), 64'd0);
        chk({tag, "_ready"}, 64'(cfg.ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        cfg.valid = 1'b0;
        cfg.data = 16'h0;
        cfg.last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_init");
        reset = 1'b1;
        @(posedge clk); #1;

        // Full program, valid held high: 8 cycles per row, done 32 cycles after start.
        run(0, 11, 0, 4'b0, 100);
        check_full("full");
        chk("full_done_cyc", 64'(done_cyc), 64'd32);

        // last on word 3 (end of row 0): error on that transfer, no strobe at all.
        run(0, 2, 0, 4'b0, 100);
        chk("early_last_err", 64'(err), 64'd1);
        chk("early_last_err_cyc", 64'(err_cyc), 64'd3);
        chk("early_last_pulses", 64'(n_pulses), 64'd0);
        chk("early_last_wl", 64'(cfg_wl), 64'd0);
        chk("early_last_busy", 64'(busy), 64'd0);
        chk("early_last_done", 64'(done), 64'd0);
        chk("early_last_ready", 64'(cfg.ready), 64'd0);

        // last missing on word 12: rows 0-2 strobe, error after word 12, row 3 never strobes.
        run(0, -1, 0, 4'b0, 100);
        chk("no_last_err", 64'(err), 64'd1);
        chk("no_last_err_cyc", 64'(err_cyc), 64'd27);
        chk("no_last_pulses", 64'(n_pulses), 64'd3);
        chk("no_last_row3_len", 64'(wl_cnt[3]), 64'd0);
        chk("no_last_row2_len", 64'(wl_cnt[2]), 64'd2);
        chk("no_last_wl", 64'(cfg_wl), 64'd0);

        // Random valid gaps: same strobe/frame sequence, just slower.
        run(1, 11, 0, 4'b0, 400);
        check_full("gaps");

        // Reset in the middle of the row 2 strobe clears WL immediately.
        run(0, 11, 0, 4'b0100, 100);
        chk("mid_rst_reached", 64'(timed_out), 64'd0);
        chk("mid_rst_wl_before", 64'(cfg_wl), 64'(4'b0100));
        reset = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run(0, 11, 0, 4'b0, 100);
        check_full("after_rst");
        chk("after_rst_done_cyc", 64'(done_cyc), 64'd32);

        // start during LOAD and during PULSE is ignored.
        run(0, 11, 1, 4'b0, 100);
        check_full("inject");
        chk("inject_done_cyc", 64'(done_cyc), 64'd32);

        // start from DONE clears done and reprograms from row 0.
        run(0, 11, 0, 4'b0, 100);
        check_full("from_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
